// File: rtl/univ_shift_pkg.sv
// Shared definitions for the universal shift register: command codes, FSM
// states and the single-step shift/rotate function.
package univ_shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'd0,
        MODE_LOAD  = 3'd1,
        MODE_SHL   = 3'd2,
        MODE_SHR   = 3'd3,
        MODE_ROL   = 3'd4,
        MODE_ROR   = 3'd5,
        MODE_CLEAR = 3'd6,
        MODE_RSVD  = 3'd7
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int MAX_WIDTH = 64;

    function automatic logic is_shift_mode(input mode_e m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
    endfunction

    // One single-bit step on a register of 'width' bits held in the low bits of
    // a 64-bit container; non-shift modes return q unchanged.
    function automatic logic [MAX_WIDTH-1:0] step_q(
        input logic [MAX_WIDTH-1:0] q,
        input int unsigned          width,
        input mode_e                m,
        input logic                 sin
    );
        logic [MAX_WIDTH-1:0] mask;
        logic [MAX_WIDTH-1:0] top;
        logic [MAX_WIDTH-1:0] r;
        mask = (width >= MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
        top  = 64'd1 << (width - 1);
        case (m)
            MODE_SHL: r = (q << 1) | {63'd0, sin};
            MODE_SHR: r = (q >> 1) | (sin ? top : 64'd0);
            MODE_ROL: r = (q << 1) | {63'd0, ((q & top) != 64'd0)};
            MODE_ROR: r = (q >> 1) | (q[0] ? top : 64'd0);
            default:  r = q;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: load/clear/hold in one cycle, multi-bit
// shifts and rotates one bit per cycle with busy/done status.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] shift_amt,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out_msb,
    output logic             serial_out_lsb,
    output logic             busy,
    output logic             done
);

    state_e           state_reg, state_next;
    mode_e            mode_reg, mode_next;
    logic [AMT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             done_reg, done_next;

    mode_e            cmd_mode;
    mode_e            step_mode;
    logic [AMT_W-1:0] amt_eff;
    logic [WIDTH-1:0] q_stepped;

    assign cmd_mode  = mode_e'(mode);
    assign amt_eff   = (shift_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : shift_amt;
    // While shifting, the latched mode drives the step; in IDLE the incoming one does.
    assign step_mode = (state_reg == SHIFT) ? mode_reg : cmd_mode;
    assign q_stepped = WIDTH'(step_q(MAX_WIDTH'(q_reg), WIDTH, step_mode, serial_in));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            mode_reg  <= MODE_HOLD;
            cnt_reg   <= '0;
            q_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        cnt_next   = cnt_reg;
        q_next     = q_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    mode_next = cmd_mode;
                    if (is_shift_mode(cmd_mode)) begin
                        if (amt_eff == '0) begin
                            done_next = 1'b1;
                        end else begin
                            q_next = q_stepped;
                            if (amt_eff == AMT_W'(1)) begin
                                done_next = 1'b1;
                            end else begin
                                state_next = SHIFT;
                                cnt_next   = amt_eff - AMT_W'(1);
                            end
                        end
                    end else begin
                        case (cmd_mode)
                            MODE_LOAD:  q_next = parallel_in;
                            MODE_CLEAR: q_next = '0;
                            default:    q_next = q_reg;
                        endcase
                        done_next = 1'b1;
                    end
                end
            end
            SHIFT: begin
                q_next   = q_stepped;
                cnt_next = cnt_reg - AMT_W'(1);
                if (cnt_reg == AMT_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy           = (state_reg == SHIFT);
    assign cmd_ready      = !busy;
    assign done           = done_reg;
    assign parallel_out   = q_reg;
    assign serial_out_msb = q_reg[WIDTH-1];
    assign serial_out_lsb = q_reg[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8): per-cycle comparison against a
// command-level model plus hand-computed literal checkpoints.
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       mode;
    logic [AMT_W-1:0] shift_amt;
    logic [WIDTH-1:0] parallel_in;
    logic             serial_in;
    logic [WIDTH-1:0] parallel_out;
    logic             serial_out_msb;
    logic             serial_out_lsb;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .mode           (mode),
        .shift_amt      (shift_amt),
        .parallel_in    (parallel_in),
        .serial_in      (serial_in),
        .parallel_out   (parallel_out),
        .serial_out_msb (serial_out_msb),
        .serial_out_lsb (serial_out_lsb),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: register value, bit steps still owed, and the pending done pulse.
    logic [7:0] m_q;
    int         m_left;
    logic [2:0] m_mode;
    logic       m_done;

    function automatic logic [7:0] apply_op(input logic [2:0] op, input logic [7:0] v, input logic s);
        int x;
        x = int'(v);
        case (op)
            3'd2:    x = (x * 2 + int'(s)) % 256;
            3'd3:    x = x / 2 + (s ? 128 : 0);
            3'd4:    x = (x * 2) % 256 + x / 128;
            3'd5:    x = x / 2 + (x % 2) * 128;
            default: x = x;
        endcase
        return 8'(x);
    endfunction

    always @(posedge clk) begin : model
        logic [7:0] q;
        int         left;
        int         n;
        logic       nd;
        logic [2:0] mm;
        q = m_q; left = m_left; mm = m_mode; nd = 1'b0;
        if (reset) begin
            q = 8'h00; left = 0; nd = 1'b0;
        end else if (left > 0) begin
            q = apply_op(mm, q, serial_in);
            left = left - 1;
            nd = (left == 0);
        end else if (cmd_valid) begin
            case (mode)
                3'd1: begin q = parallel_in; nd = 1'b1; end
                3'd6: begin q = 8'h00;       nd = 1'b1; end
                3'd2, 3'd3, 3'd4, 3'd5: begin
                    n  = (int'(shift_amt) > 8) ? 8 : int'(shift_amt);
                    mm = mode;
                    if (n > 0) q = apply_op(mode, q, serial_in);
                    left = (n > 0) ? n - 1 : 0;
                    nd = (left == 0);
                end
                default: nd = 1'b1;
            endcase
        end
        m_q    <= q;
        m_left <= left;
        m_mode <= mm;
        m_done <= nd;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output with the model.
    task automatic tick();
        @(negedge clk);
        chk("parallel_out", 64'(parallel_out), 64'(m_q));
        chk("serial_out_msb", 64'(serial_out_msb), 64'(m_q[7]));
        chk("serial_out_lsb", 64'(serial_out_lsb), 64'(m_q[0]));
        chk("busy", 64'(busy), 64'(m_left > 0));
        chk("cmd_ready", 64'(cmd_ready), 64'(m_left == 0));
        chk("done", 64'(done), 64'(m_done));
    endtask

    // Present a command for one accepting edge and return at the next falling edge.
    task automatic issue(input logic [2:0] m, input int amt, input logic [7:0] pin, input logic s);
        cmd_valid = 1'b1; mode = m; shift_amt = AMT_W'(amt); parallel_in = pin; serial_in = s;
        tick();
        cmd_valid = 1'b0;
        $display("cmd mode=%0d amt=%0d pin=0x%02h sin=%0b -> q=0x%02h busy=%0b done=%0b",
                 m, amt, pin, s, parallel_out, busy, done);
    endtask

    // Count falling edges (starting at 1 for the edge right after acceptance) until done.
    task automatic wait_done(input string name, input int exp_cycles);
        int k;
        k = 1;
        while (!done && k < 40) begin
            tick();
            k++;
        end
        chk(name, 64'(k), 64'(exp_cycles));
    endtask

    initial begin
        int busy_cycles;
        int done_seen;
        reset = 1'b1; cmd_valid = 1'b0; mode = 3'd0; shift_amt = '0;
        parallel_in = '0; serial_in = 1'b0;
        m_q = 8'h00; m_left = 0; m_mode = 3'd0; m_done = 1'b0;
        tick(); tick();
        chk("reset_q", 64'(parallel_out), 64'h00);
        chk("reset_ready", 64'(cmd_ready), 64'd1);
        reset = 1'b0;
        tick();

        // Reset in the middle of a 5-step shift.
        issue(3'd1, 0, 8'hA5, 1'b0);
        chk("load_a5", 64'(parallel_out), 64'hA5);
        tick();
        issue(3'd2, 5, 8'h00, 1'b0);
        tick();
        chk("shl_mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_q", 64'(parallel_out), 64'h00);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(cmd_ready), 64'd1);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) done_seen++;
        end
        chk("abort_no_done", 64'(done_seen), 64'd0);

        // ROL 3 on 0x3C, then ROR 8 returns the value unchanged.
        issue(3'd1, 0, 8'h3C, 1'b0);
        tick();
        issue(3'd4, 3, 8'h00, 1'b0);
        busy_cycles = busy ? 1 : 0;
        while (busy && busy_cycles < 20) begin
            tick();
            if (busy) busy_cycles++;
        end
        chk("rol3_busy_cycles", 64'(busy_cycles), 64'd2);
        chk("rol3_done", 64'(done), 64'd1);
        chk("rol3_q", 64'(parallel_out), 64'hE1);
        tick();
        issue(3'd5, 8, 8'h00, 1'b0);
        wait_done("ror8_cycles", 8);
        chk("ror8_q", 64'(parallel_out), 64'hE1);
        tick();

        // SHR 4 on 0xF0 with serial_in 1,0,1,1 on successive steps.
        issue(3'd1, 0, 8'hF0, 1'b0);
        tick();
        issue(3'd3, 4, 8'h00, 1'b1);
        chk("shr_step1", 64'(parallel_out), 64'hF8);
        serial_in = 1'b0; tick();
        chk("shr_step2", 64'(parallel_out), 64'h7C);
        serial_in = 1'b1; tick();
        serial_in = 1'b1; tick();
        chk("shr4_done", 64'(done), 64'd1);
        chk("shr4_q", 64'(parallel_out), 64'hDF);
        chk("shr4_lsb", 64'(serial_out_lsb), 64'd1);
        serial_in = 1'b0;
        tick();

        // Saturating amount: 15 behaves as 8.
        issue(3'd1, 0, 8'hFF, 1'b0);
        tick();
        issue(3'd2, 15, 8'h00, 1'b0);
        wait_done("shl15_cycles", 8);
        chk("shl15_q", 64'(parallel_out), 64'h00);
        tick();

        // LOAD held during busy is ignored, then accepted in the done cycle.
        issue(3'd1, 0, 8'hE1, 1'b0);
        tick();
        issue(3'd2, 2, 8'h00, 1'b0);
        cmd_valid = 1'b1; mode = 3'd1; parallel_in = 8'h55;
        chk("busy_ready_low", 64'(cmd_ready), 64'd0);
        tick();
        chk("ignored_load_q", 64'(parallel_out), 64'h84);
        chk("done_cycle_ready", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        chk("backtoback_q", 64'(parallel_out), 64'h55);
        chk("backtoback_done", 64'(done), 64'd1);
        tick();

        // Reserved mode, CLEAR, zero-amount shift: single done, never busy.
        issue(3'd7, 0, 8'h00, 1'b0);
        wait_done("rsvd_cycles", 1);
        chk("rsvd_q", 64'(parallel_out), 64'h55);
        tick();
        chk("rsvd_single_done", 64'(done), 64'd0);
        issue(3'd6, 0, 8'h00, 1'b0);
        wait_done("clear_cycles", 1);
        chk("clear_q", 64'(parallel_out), 64'h00);
        tick();
        issue(3'd1, 0, 8'h5A, 1'b0);
        tick();
        issue(3'd2, 0, 8'h00, 1'b1);
        wait_done("shl0_cycles", 1);
        chk("shl0_busy", 64'(busy), 64'd0);
        chk("shl0_q", 64'(parallel_out), 64'h5A);
        tick();
        chk("shl0_single_done", 64'(done), 64'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
